// File: rtl/gpio_pkg.sv
// GPIO shared definitions: register byte offsets, AHB-Lite HTRANS encodings,
// and the default read word returned by the GPIO splitter for unclaimed space.
// Latency: n/a (package).  Backpressure: n/a.
package gpio_pkg;

    // Register byte offsets within one GPIO port window.
    localparam logic [7:0] GPIO_DIN_OFF  = 8'h00;
    localparam logic [7:0] GPIO_DOUT_OFF = 8'h04;
    localparam logic [7:0] GPIO_DIR_OFF  = 8'h08;
    localparam logic [7:0] GPIO_EDGE_OFF = 8'h0C;
    localparam logic [7:0] GPIO_IE_OFF   = 8'h10;
    localparam logic [7:0] GPIO_IS_OFF   = 8'h14;
    localparam logic [7:0] GPIO_DSET_OFF = 8'h18;
    localparam logic [7:0] GPIO_DCLR_OFF = 8'h1C;

    // AHB-Lite transfer types.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Read data the splitter returns when no port is selected.
    localparam logic [31:0] GPIO_DEFAULT_RDATA = 32'hBADD_BEEF;

    // Word index (HADDR[7:2]) of a byte offset.
    function automatic logic [5:0] gpio_widx(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer plus a history flop and per-pin edge select.
// Latency: pad change visible on sync_o after 2 edges, ev_o pulses for 1 cycle after that.
// Backpressure: none, samples every cycle.
// Ports: HCLK/HRESETn clock and async active-low reset; gpio_in_i raw pads;
//        edge_rise_i per-pin edge polarity (1 = rising); sync_o synchronized
//        pad state; ev_o one-cycle edge event per pin.
module gpio_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] gpio_in_i,
    input  logic [WIDTH-1:0] edge_rise_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] ev_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sync_o = sync2_q;
    assign ev_o   = (edge_rise_i  &  sync2_q & ~prev_q)
                  | (~edge_rise_i & ~sync2_q &  prev_q);

endmodule

// File: rtl/ahbl_gpio_port.sv
// AHB-Lite slave for one GPIO port: data out, direction, synchronized input,
// edge status with W1C clear and a maskable level interrupt.
// Latency: zero wait states, writes land at end of data phase.  Backpressure: HREADYOUT tied 1.
// Ports: AHB-Lite slave (HSEL..HRESP) from the GPIO splitter; GPIO_IN async pads;
//        GPIO_OUT/GPIO_OE pad drive; IRQ active-high level interrupt.
module ahbl_gpio_port
    import gpio_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RST_DOUT = '0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             IRQ
);

    localparam logic [5:0] IDX_DIN  = gpio_widx(GPIO_DIN_OFF);
    localparam logic [5:0] IDX_DOUT = gpio_widx(GPIO_DOUT_OFF);
    localparam logic [5:0] IDX_DIR  = gpio_widx(GPIO_DIR_OFF);
    localparam logic [5:0] IDX_EDGE = gpio_widx(GPIO_EDGE_OFF);
    localparam logic [5:0] IDX_IE   = gpio_widx(GPIO_IE_OFF);
    localparam logic [5:0] IDX_IS   = gpio_widx(GPIO_IS_OFF);
    localparam logic [5:0] IDX_DSET = gpio_widx(GPIO_DSET_OFF);
    localparam logic [5:0] IDX_DCLR = gpio_widx(GPIO_DCLR_OFF);

    // Address-phase capture.
    logic [5:0] addr_q, addr_d;
    logic       wr_q,   wr_d;
    logic       act_q,  act_d;

    // Register file.
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] ie_q,   ie_d;
    logic [WIDTH-1:0] is_q,   is_d;

    logic [WIDTH-1:0] din_sync;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] w1c_mask;
    logic             xfer_vld;
    logic             wr_en;
    logic [31:0]      rdata;

    // Address bits outside [7:2], HTRANS[0] and HWDATA above WIDTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .gpio_in_i   (GPIO_IN),
        .edge_rise_i (edge_q),
        .sync_o      (din_sync),
        .ev_o        (ev)
    );

    assign xfer_vld = HSEL & HTRANS[1] & HREADY;
    // Commit only when the data phase actually completes on the bus.
    assign wr_en    = act_q & wr_q & HREADY;
    assign wdat     = HWDATA[WIDTH-1:0];

    always_comb begin
        addr_d = addr_q;
        wr_d   = wr_q;
        act_d  = act_q;
        if (xfer_vld) begin
            addr_d = HADDR[7:2];
            wr_d   = HWRITE;
            act_d  = 1'b1;
        end else if (HREADY) begin
            act_d  = 1'b0;
        end
    end

    always_comb begin
        dout_d   = dout_q;
        dir_d    = dir_q;
        edge_d   = edge_q;
        ie_d     = ie_q;
        w1c_mask = '0;
        if (wr_en) begin
            case (addr_q)
                IDX_DOUT: dout_d   = wdat;
                IDX_DIR:  dir_d    = wdat;
                IDX_EDGE: edge_d   = wdat;
                IDX_IE:   ie_d     = wdat;
                IDX_IS:   w1c_mask = wdat;
                IDX_DSET: dout_d   = dout_q | wdat;
                IDX_DCLR: dout_d   = dout_q & ~wdat;
                default:  ;
            endcase
        end
        // A fresh event survives a same-cycle clear so no edge is lost.
        is_d = (is_q & ~w1c_mask) | ev;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            act_q  <= 1'b0;
            dout_q <= RST_DOUT;
            dir_q  <= '0;
            edge_q <= '0;
            ie_q   <= '0;
            is_q   <= '0;
        end else begin
            addr_q <= addr_d;
            wr_q   <= wr_d;
            act_q  <= act_d;
            dout_q <= dout_d;
            dir_q  <= dir_d;
            edge_q <= edge_d;
            ie_q   <= ie_d;
            is_q   <= is_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (act_q) begin
            case (addr_q)
                IDX_DIN:  rdata[WIDTH-1:0] = din_sync;
                IDX_DOUT: rdata[WIDTH-1:0] = dout_q;
                IDX_DIR:  rdata[WIDTH-1:0] = dir_q;
                IDX_EDGE: rdata[WIDTH-1:0] = edge_q;
                IDX_IE:   rdata[WIDTH-1:0] = ie_q;
                IDX_IS:   rdata[WIDTH-1:0] = is_q;
                default:  rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign GPIO_OUT  = dout_q;
    assign GPIO_OE   = dir_q;
    assign IRQ       = |(is_q & ie_q);

endmodule

// File: tb/tb_ahbl_gpio_port.sv
// Directed bench for ahbl_gpio_port (WIDTH=16, RST_DOUT=0).
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_ahbl_gpio_port;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] GPIO_IN;
    logic [15:0] GPIO_OUT;
    logic [15:0] GPIO_OE;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahbl_gpio_port #(.WIDTH(16), .RST_DOUT(16'h0000)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .GPIO_IN   (GPIO_IN),
        .GPIO_OUT  (GPIO_OUT),
        .GPIO_OE   (GPIO_OE),
        .IRQ       (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        tick();
        bus_idle();
        HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        tick();
        bus_idle();
        #3;
        d = HRDATA;
        tick();
    endtask

    logic [31:0] rd;

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HWDATA  = 32'h0;
        GPIO_IN = 16'h0000;
        bus_idle();

        // Reset state.
        tick(3);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp",     {31'd0, HRESP},     32'd0);
        HRESETn = 1'b1;
        tick();
        check("rst_oe",   {16'd0, GPIO_OE},  32'h0);
        check("rst_out",  {16'd0, GPIO_OUT}, 32'h0);
        check("rst_irq",  {31'd0, IRQ},      32'h0);
        ahb_read(32'h04, rd); check("rst_rd_dout", rd, 32'h0);
        ahb_read(32'h08, rd); check("rst_rd_dir",  rd, 32'h0);
        ahb_read(32'h14, rd); check("rst_rd_is",   rd, 32'h0);

        // Back-to-back write then read of DOUT.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        HWRITE = 1'b0; HADDR = 32'h04; HWDATA = 32'h0000_A5A5;
        tick();
        bus_idle();
        #3;
        check("b2b_hrdata",   HRDATA, 32'h0000_A5A5);
        check("b2b_gpio_out", {16'd0, GPIO_OUT}, 32'h0000_A5A5);
        tick();

        // Set / clear from DOUT=0x000F.
        ahb_write(32'h04, 32'h0000_000F);
        ahb_write(32'h18, 32'h0000_00F0);
        ahb_write(32'h1C, 32'h0000_0005);
        check("setclr_out", {16'd0, GPIO_OUT}, 32'h0000_00FA);
        ahb_read(32'h04, rd); check("setclr_rd",  rd, 32'h0000_00FA);
        ahb_read(32'h18, rd); check("dset_rd0",   rd, 32'h0);

        // Rising-edge interrupt on pin 0, three edges after the pad change.
        ahb_write(32'h0C, 32'h0000_0001);
        ahb_write(32'h10, 32'h0000_0001);
        GPIO_IN[0] = 1'b1;
        tick(2);
        check("rise_irq_2edges", {31'd0, IRQ}, 32'd0);
        tick();
        check("rise_irq_3edges", {31'd0, IRQ}, 32'd1);
        ahb_read(32'h14, rd); check("rise_is", rd, 32'h1);
        ahb_write(32'h14, 32'h0000_0001);
        check("w1c_irq", {31'd0, IRQ}, 32'd0);
        ahb_read(32'h14, rd); check("w1c_is", rd, 32'h0);

        // Pending status with IE off, then enabling IE raises IRQ.
        ahb_write(32'h10, 32'h0);
        GPIO_IN[0] = 1'b0;
        tick(4);
        GPIO_IN[0] = 1'b1;
        tick(4);
        check("masked_irq", {31'd0, IRQ}, 32'd0);
        ahb_read(32'h14, rd); check("masked_is", rd, 32'h1);
        ahb_write(32'h10, 32'h0000_0001);
        check("ie_late_irq", {31'd0, IRQ}, 32'd1);
        ahb_write(32'h14, 32'h0000_FFFF);
        check("clear_all_irq", {31'd0, IRQ}, 32'd0);

        // Falling edge on pin 3 coinciding with its W1C.
        GPIO_IN[3] = 1'b1;
        tick(4);
        GPIO_IN[3] = 1'b0;
        tick(3);
        ahb_read(32'h14, rd); check("fall_is", rd, 32'h8);
        GPIO_IN[3] = 1'b1;
        tick(4);
        GPIO_IN[3] = 1'b0;
        tick();
        ahb_write(32'h14, 32'h0000_0008);
        ahb_read(32'h14, rd); check("ev_beats_w1c", rd, 32'h8);
        ahb_write(32'h14, 32'h0000_0008);
        ahb_read(32'h14, rd); check("w1c_alone", rd, 32'h0);

        // Filtering: deselected and IDLE writes do nothing.
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        HWDATA = 32'h0000_FFFF;
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h08;
        tick();
        bus_idle();
        HWDATA = 32'h0000_EEEE;
        tick();
        check("filt_out", {16'd0, GPIO_OUT}, 32'h0000_00FA);
        ahb_read(32'h08, rd); check("filt_dir", rd, 32'h0);
        ahb_read(32'h40, rd); check("unmapped_rd", rd, 32'h0);
        ahb_write(32'h00, 32'h0000_FFFF);
        ahb_read(32'h00, rd); check("din_ro", rd, 32'h0000_0001);

        // HREADY stall between address and data phase.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
        tick();
        HREADY = 1'b0;
        HADDR  = 32'h04;
        HWDATA = 32'h0000_1234;
        tick(2);
        HREADY = 1'b1;
        bus_idle();
        tick();
        check("stall_oe",  {16'd0, GPIO_OE},  32'h0000_1234);
        check("stall_out", {16'd0, GPIO_OUT}, 32'h0000_00FA);

        // Reset during the data phase of a write drops it.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        bus_idle();
        HWDATA = 32'h0000_5555;
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_out", {16'd0, GPIO_OUT}, 32'h0);
        check("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        tick();
        HRESETn = 1'b1;
        tick();
        ahb_read(32'h04, rd); check("midrst_rd_dout", rd, 32'h0);
        check("midrst_oe", {16'd0, GPIO_OE}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_gpio_port.md
Name: ahbl_gpio_port

Overview:
- AHB-Lite slave for one GPIO port (A, B or C).
- Sits directly downstream of the GPIO splitter: takes its per-port select as HSEL, returns HRDATA/HREADYOUT to it.
- Provides output data, per-pin direction, a 2-flop input synchronizer, edge detection and a maskable level interrupt.
- Zero-wait-state, word-access register file.

Parameters:
- WIDTH, 16, number of GPIO pins (1..32); register bits above WIDTH read 0 and ignore writes.
- RST_DOUT, 0, reset value of DATAOUT[WIDTH-1:0].

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low. Clock is HCLK.
- HSEL  in  1  port select from splitter.
- HADDR  in  32  address; only [7:2] decoded.
- HTRANS  in  2  transfer type; bit 1 marks NONSEQ/SEQ.
- HWRITE  in  1  write strobe.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready (splitter mux output).
- HRDATA  out  32  read data, data phase.
- HREADYOUT  out  1  tied 1.
- HRESP  out  1  tied 0 (OKAY).
- GPIO_IN  in  WIDTH  pad inputs, asynchronous to HCLK.
- GPIO_OUT  out  WIDTH  pad output values.
- GPIO_OE  out  WIDTH  pad output enables (1 = drive).
- IRQ  out  1  interrupt, active-high level.

Behaviour:
- Address phase. Transfer is valid when HSEL & HTRANS[1] & HREADY.
  - On a valid transfer: latch addr_d <= HADDR[7:2], wr_d <= HWRITE, act_d <= 1.
  - When HREADY=1 and no valid transfer: act_d <= 0.
  - When HREADY=0: hold addr_d, wr_d and act_d.
  - HSIZE is not connected. Every access is a full word.
- Data phase, write (act_d & wr_d). Registers capture HWDATA at the end of the data-phase cycle.
  - A read of the same register in the following data phase returns the new value.
- Data phase, read. HRDATA is combinational from addr_d and the register state.
  - HRDATA = 0 when act_d=0 or the offset is unmapped.
- Register map (byte offset):
  - 0x00 DIN, RO: synchronized input, sync2.
  - 0x04 DOUT, RW: drives GPIO_OUT. Reset RST_DOUT.
  - 0x08 DIR, RW: drives GPIO_OE. Reset 0, so all pins are inputs.
  - 0x0C EDGE, RW: per pin, 1 = rising, 0 = falling. Reset 0.
  - 0x10 IE, RW: interrupt enable. Reset 0.
  - 0x14 IS, W1C: edge status. Writing 1 clears the bit, writing 0 has no effect. Reset 0.
  - 0x18 DSET, WO: DOUT |= HWDATA. Reads 0.
  - 0x1C DCLR, WO: DOUT &= ~HWDATA. Reads 0.
  - Writes to DIN, or to an unmapped offset, are ignored.
- Synchronizer: sync1 <= GPIO_IN, sync2 <= sync1, prev <= sync2. All reset to 0.
- Edge detect:
  - ev = EDGE ? (sync2 & ~prev) : (~sync2 & prev).
  - Detected on every cycle, including pins configured as outputs; reads back pad state.
  - Latency: a GPIO_IN transition sets IS 3 HCLK edges later.
- IS update per bit: IS <= (IS & ~w1c_mask) | ev. A new event wins over a simultaneous clear.
- IRQ = |(IS & IE). Combinational from flops, so glitch-free.
  - Setting IE with IS already pending asserts IRQ the cycle after the write.
- Reset mid-transfer: all state returns to reset values asynchronously, act_d=0, and the in-flight write is lost.
- HREADYOUT=1 and HRESP=0 at all times, including during reset.

Decomposition:
- Shared package gpio_pkg:
  - register offset constants (GPIO_DIN_OFF .. GPIO_DCLR_OFF);
  - HTRANS encodings;
  - the BADDBEEF default-read constant used by the splitter.
- One sub-module, gpio_sync_edge:
  - contains the 2-flop synchronizer, prev flop and edge select;
  - parameterized by WIDTH;
  - outputs sync2 and ev.

Test Plan:
- Reset: hold HRESETn=0, then release -> GPIO_OE=0, GPIO_OUT=RST_DOUT, IRQ=0, reads of 0x04/0x08/0x14 return 0.
- Back-to-back access: write 0x0000A5A5 to 0x04, then read 0x04 in the next transfer -> HRDATA=0x0000A5A5, GPIO_OUT=0xA5A5.
- Set/clear: write 0x00F0 to 0x18, then 0x0005 to 0x1C, starting from DOUT=0x000F -> DOUT=0x00FA.
- Rising-edge interrupt: EDGE=0x0001, IE=0x0001, drive GPIO_IN[0] 0->1 -> IS[0]=1 and IRQ=1 exactly 3 cycles later; write 0x1 to 0x14 -> IRQ=0.
- Falling edge coincident with W1C: EDGE[3]=0, new falling event on pin 3 in the same cycle as a W1C of bit 3 -> IS[3] stays 1.
- Filtering: HSEL=0 or HTRANS=IDLE with HWRITE=1 -> no register changes. Read of unmapped offset 0x40 -> 0. HREADY=0 stall between address and data phase -> latched address held and write lands correctly.
